// File: rtl/lock_table_mgr.sv
// -----------------------------------------------------------------------------
// lock_table_mgr
//
// Lock table for the Picos/HWR command path (HWR ID 0x15). Accelerators send
// lock (0x04) and unlock (0x06) commands naming a lock id. The block keeps up
// to NUM_LOCKS entries {valid, lock_id, owner} and answers with ACK words
// (0x01 ok, 0x00 reject) routed back to the requester.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   cmd_tvalid/tready/tdata   command stream; tdata[7:0] code,
//                             tdata[8 +: LOCK_ID_BITS] lock id
//   cmd_tid                   requester accelerator id
//   ack_tvalid/tready/tdata   ACK stream; tdata is 0x00 or 0x01
//   ack_tdest                 requester id echoed with the ACK
//   locks_held                number of valid table entries
//   err_sticky                set on any illegal command until reset
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | ready for a command (cmd_tready=1), capture it on handshake
// ST_LOOKUP | one cycle: match lock id, update table, decide on an ACK
// ST_RESP   | hold ACK valid/data/dest stable until ack_tready
// -----------------------------------------------------------------------------
module lock_table_mgr #(
  parameter int unsigned NUM_LOCKS    = 4,
  parameter int unsigned LOCK_ID_BITS = 8,
  parameter int unsigned ACCID_BITS   = 8,
  parameter bit          UNLOCK_ACK   = 1'b0,
  localparam int unsigned CNT_W       = $clog2(NUM_LOCKS + 1)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    cmd_tvalid,
  output logic                    cmd_tready,
  input  logic [63:0]             cmd_tdata,
  input  logic [ACCID_BITS-1:0]   cmd_tid,
  output logic                    ack_tvalid,
  input  logic                    ack_tready,
  output logic [63:0]             ack_tdata,
  output logic [ACCID_BITS-1:0]   ack_tdest,
  output logic [CNT_W-1:0]        locks_held,
  output logic                    err_sticky
);

  localparam logic [7:0] CODE_LOCK   = 8'h04;
  localparam logic [7:0] CODE_UNLOCK = 8'h06;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_RESP
  } state_t;

  state_t                  state_q, state_d;
  logic [7:0]              cmd_code_q, cmd_code_d;
  logic [LOCK_ID_BITS-1:0] cmd_id_q, cmd_id_d;
  logic [ACCID_BITS-1:0]   cmd_tid_q, cmd_tid_d;

  logic [NUM_LOCKS-1:0]    ent_valid_q, ent_valid_d;
  logic [LOCK_ID_BITS-1:0] ent_id_q    [NUM_LOCKS];
  logic [LOCK_ID_BITS-1:0] ent_id_d    [NUM_LOCKS];
  logic [ACCID_BITS-1:0]   ent_owner_q [NUM_LOCKS];
  logic [ACCID_BITS-1:0]   ent_owner_d [NUM_LOCKS];

  logic                    cmd_tready_q, cmd_tready_d;
  logic                    ack_tvalid_q, ack_tvalid_d;
  logic                    ack_ok_q, ack_ok_d;
  logic [ACCID_BITS-1:0]   ack_tdest_q, ack_tdest_d;
  logic [CNT_W-1:0]        locks_held_q, locks_held_d;
  logic                    err_sticky_q, err_sticky_d;

  logic [NUM_LOCKS-1:0]    hit_vec;
  logic [NUM_LOCKS-1:0]    own_vec;
  logic [NUM_LOCKS-1:0]    free_oh;
  logic                    free_found;
  logic                    id_hit;
  logic                    owner_ok;
  logic                    table_full;
  logic                    ack_due;

  // Only the lock-id field takes part in matching; the rest is ignored.
  logic unused_tdata;
  assign unused_tdata = ^cmd_tdata[63:8+LOCK_ID_BITS];

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_LOCKS-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_LOCKS; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

  // Parallel compare over valid entries. Ids are unique in the table, so at
  // most one bit of hit_vec is set.
  always_comb begin
    hit_vec = '0;
    own_vec = '0;
    for (int i = 0; i < NUM_LOCKS; i++) begin
      hit_vec[i] = ent_valid_q[i] && (ent_id_q[i] == cmd_id_q);
      own_vec[i] = (ent_owner_q[i] == cmd_tid_q);
    end
  end

  // One-hot of the lowest-index invalid entry.
  always_comb begin
    free_oh    = '0;
    free_found = 1'b0;
    for (int i = 0; i < NUM_LOCKS; i++) begin
      if (!ent_valid_q[i] && !free_found) begin
        free_oh[i] = 1'b1;
        free_found = 1'b1;
      end
    end
  end

  assign id_hit     = |hit_vec;
  assign owner_ok   = |(hit_vec & own_vec);
  assign table_full = ~free_found;

  always_comb begin
    state_d      = state_q;
    cmd_code_d   = cmd_code_q;
    cmd_id_d     = cmd_id_q;
    cmd_tid_d    = cmd_tid_q;
    ent_valid_d  = ent_valid_q;
    ent_id_d     = ent_id_q;
    ent_owner_d  = ent_owner_q;
    cmd_tready_d = cmd_tready_q;
    ack_tvalid_d = ack_tvalid_q;
    ack_ok_d     = ack_ok_q;
    ack_tdest_d  = ack_tdest_q;
    err_sticky_d = err_sticky_q;
    ack_due      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_tready_d = 1'b1;
        if (cmd_tvalid && cmd_tready_q) begin
          cmd_code_d   = cmd_tdata[7:0];
          cmd_id_d     = cmd_tdata[8 +: LOCK_ID_BITS];
          cmd_tid_d    = cmd_tid;
          cmd_tready_d = 1'b0;
          state_d      = ST_LOOKUP;
        end
      end

      ST_LOOKUP: begin
        case (cmd_code_q)
          CODE_LOCK: begin
            ack_due  = 1'b1;
            ack_ok_d = 1'b0;
            // A held id is rejected even when the requester already owns it.
            if (!id_hit && !table_full) begin
              ent_valid_d = ent_valid_q | free_oh;
              for (int i = 0; i < NUM_LOCKS; i++) begin
                if (free_oh[i]) begin
                  ent_id_d[i]    = cmd_id_q;
                  ent_owner_d[i] = cmd_tid_q;
                end
              end
              ack_ok_d = 1'b1;
            end
          end
          CODE_UNLOCK: begin
            ack_due  = UNLOCK_ACK;
            ack_ok_d = 1'b0;
            if (owner_ok) begin
              ent_valid_d = ent_valid_q & ~hit_vec;
              ack_ok_d    = 1'b1;
            end else begin
              err_sticky_d = 1'b1;
            end
          end
          default: begin
            err_sticky_d = 1'b1;
          end
        endcase

        if (ack_due) begin
          ack_tdest_d  = cmd_tid_q;
          ack_tvalid_d = 1'b1;
          cmd_tready_d = 1'b0;
          state_d      = ST_RESP;
        end else begin
          cmd_tready_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end

      ST_RESP: begin
        // Intake stays closed while the ACK is backpressured.
        if (ack_tready) begin
          ack_tvalid_d = 1'b0;
          cmd_tready_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        state_d      = ST_IDLE;
        ack_tvalid_d = 1'b0;
        cmd_tready_d = 1'b0;
      end
    endcase

    locks_held_d = popcount(ent_valid_d);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      cmd_code_q   <= '0;
      cmd_id_q     <= '0;
      cmd_tid_q    <= '0;
      ent_valid_q  <= '0;
      for (int i = 0; i < NUM_LOCKS; i++) begin
        ent_id_q[i]    <= '0;
        ent_owner_q[i] <= '0;
      end
      cmd_tready_q <= 1'b0;
      ack_tvalid_q <= 1'b0;
      ack_ok_q     <= 1'b0;
      ack_tdest_q  <= '0;
      locks_held_q <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_code_q   <= cmd_code_d;
      cmd_id_q     <= cmd_id_d;
      cmd_tid_q    <= cmd_tid_d;
      ent_valid_q  <= ent_valid_d;
      for (int i = 0; i < NUM_LOCKS; i++) begin
        ent_id_q[i]    <= ent_id_d[i];
        ent_owner_q[i] <= ent_owner_d[i];
      end
      cmd_tready_q <= cmd_tready_d;
      ack_tvalid_q <= ack_tvalid_d;
      ack_ok_q     <= ack_ok_d;
      ack_tdest_q  <= ack_tdest_d;
      locks_held_q <= locks_held_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign cmd_tready = cmd_tready_q;
  assign ack_tvalid = ack_tvalid_q;
  assign ack_tdata  = {63'd0, ack_ok_q};
  assign ack_tdest  = ack_tdest_q;
  assign locks_held = locks_held_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_lock_table_mgr.sv
// -----------------------------------------------------------------------------
// tb_lock_table_mgr
//
// Two instances: index 0 with silent unlocks, index 1 with unlock ACKs.
// Directed vectors, hand-written backpressure / reset sequences, then random
// commands checked against a map-based model of the lock table.
// -----------------------------------------------------------------------------
module tb_lock_table_mgr;

  localparam int NL = 4;
  localparam int CW = $clog2(NL + 1);

  logic            clk;
  logic            rstn       [2];
  logic            cmd_tvalid [2];
  logic            cmd_tready [2];
  logic [63:0]     cmd_tdata  [2];
  logic [7:0]      cmd_tid    [2];
  logic            ack_tvalid [2];
  logic            ack_tready [2];
  logic [63:0]     ack_tdata  [2];
  logic [7:0]      ack_tdest  [2];
  logic [CW-1:0]   locks_held [2];
  logic            err_sticky [2];

  int n_checks = 0;
  int n_errors = 0;

  lock_table_mgr #(.NUM_LOCKS(NL), .LOCK_ID_BITS(8), .ACCID_BITS(8), .UNLOCK_ACK(1'b0)) dut0 (
    .clk(clk), .rstn(rstn[0]),
    .cmd_tvalid(cmd_tvalid[0]), .cmd_tready(cmd_tready[0]),
    .cmd_tdata(cmd_tdata[0]), .cmd_tid(cmd_tid[0]),
    .ack_tvalid(ack_tvalid[0]), .ack_tready(ack_tready[0]),
    .ack_tdata(ack_tdata[0]), .ack_tdest(ack_tdest[0]),
    .locks_held(locks_held[0]), .err_sticky(err_sticky[0])
  );

  lock_table_mgr #(.NUM_LOCKS(NL), .LOCK_ID_BITS(8), .ACCID_BITS(8), .UNLOCK_ACK(1'b1)) dut1 (
    .clk(clk), .rstn(rstn[1]),
    .cmd_tvalid(cmd_tvalid[1]), .cmd_tready(cmd_tready[1]),
    .cmd_tdata(cmd_tdata[1]), .cmd_tid(cmd_tid[1]),
    .ack_tvalid(ack_tvalid[1]), .ack_tready(ack_tready[1]),
    .ack_tdata(ack_tdata[1]), .ack_tdest(ack_tdest[1]),
    .locks_held(locks_held[1]), .err_sticky(err_sticky[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: id -> owner map per instance ----------
  bit        m_held [2][256];
  logic [7:0] m_own [2][256];
  int        m_cnt  [2];
  bit        m_err  [2];

  function automatic void model_clear();
    for (int u = 0; u < 2; u++) begin
      for (int k = 0; k < 256; k++) begin
        m_held[u][k] = 1'b0;
        m_own[u][k]  = 8'h00;
      end
      m_cnt[u] = 0;
      m_err[u] = 1'b0;
    end
  endfunction

  function automatic void model_cmd(input int u, input logic [7:0] code, input logic [7:0] id,
                                    input logic [7:0] tid, output logic ack, output logic [63:0] data);
    ack  = 1'b0;
    data = 64'd0;
    if (code == 8'h04) begin
      ack = 1'b1;
      if (!m_held[u][id] && m_cnt[u] < NL) begin
        m_held[u][id] = 1'b1;
        m_own[u][id]  = tid;
        m_cnt[u]++;
        data = 64'd1;
      end
    end else if (code == 8'h06) begin
      ack = (u == 1);
      if (m_held[u][id] && m_own[u][id] == tid) begin
        m_held[u][id] = 1'b0;
        m_cnt[u]--;
        data = 64'd1;
      end else begin
        m_err[u] = 1'b1;
      end
    end else begin
      m_err[u] = 1'b1;
    end
  endfunction

  // ---------------- driver ----------------
  task automatic wait_ready(input int u, input string name, output bit ok);
    int budget;
    budget = 0;
    @(negedge clk);
    while (!cmd_tready[u] && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    ok = cmd_tready[u];
    if (!ok) check({name, "_tready_timeout"}, {63'd0, cmd_tready[u]}, 64'd1);
  endtask

  // Handshake is at posedge N; LOOKUP in cycle N+1; results sampled in N+2.
  task automatic send(input int u, input logic [7:0] code, input logic [7:0] id,
                      input logic [7:0] tid, input logic [47:0] hi, input int ack_delay,
                      input string name,
                      output logic got_ack, output logic [63:0] got_data,
                      output logic [7:0] got_dest, output logic [7:0] got_held,
                      output logic got_err);
    bit ok;
    got_ack = 1'b0; got_data = '0; got_dest = '0; got_held = '0; got_err = 1'b0;
    ack_tready[u] = (ack_delay == 0);
    wait_ready(u, name, ok);
    if (!ok) return;
    cmd_tvalid[u] = 1'b1;
    cmd_tdata[u]  = {hi, id, code};
    cmd_tid[u]    = tid;
    @(posedge clk);
    #1;
    cmd_tvalid[u] = 1'b0;
    cmd_tdata[u]  = {$urandom, $urandom};
    @(negedge clk);
    check({name, "_lookup_ack_low"}, {63'd0, ack_tvalid[u]}, 64'd0);
    check({name, "_lookup_tready_low"}, {63'd0, cmd_tready[u]}, 64'd0);
    @(negedge clk);
    got_ack  = ack_tvalid[u];
    got_data = ack_tdata[u];
    got_dest = ack_tdest[u];
    got_held = 8'(locks_held[u]);
    got_err  = err_sticky[u];
    if (got_ack) begin
      for (int k = 0; k < ack_delay; k++) begin
        check({name, "_bp_tready_low"}, {63'd0, cmd_tready[u]}, 64'd0);
        @(negedge clk);
        check({name, "_bp_ack_valid"}, {63'd0, ack_tvalid[u]}, 64'd1);
        check({name, "_bp_ack_data"}, ack_tdata[u], got_data);
        check({name, "_bp_ack_dest"}, {56'd0, ack_tdest[u]}, {56'd0, got_dest});
      end
      ack_tready[u] = 1'b1;
      @(negedge clk);
      check({name, "_post_ack_low"}, {63'd0, ack_tvalid[u]}, 64'd0);
      check({name, "_post_tready"}, {63'd0, cmd_tready[u]}, 64'd1);
    end else begin
      check({name, "_noack_tready"}, {63'd0, cmd_tready[u]}, 64'd1);
    end
    ack_tready[u] = 1'b1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int          u;
    logic [7:0]  code;
    logic [7:0]  id;
    logic [7:0]  tid;
    logic [47:0] hi;
    logic        exp_ack;
    logic [63:0] exp_data;
    int          exp_held;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int u, input logic [7:0] code, input logic [7:0] id,
                              input logic [7:0] tid, input logic [47:0] hi, input logic exp_ack,
                              input logic [63:0] exp_data, input int exp_held, input logic exp_err);
    vec_t v;
    v.u = u; v.code = code; v.id = id; v.tid = tid; v.hi = hi;
    v.exp_ack = exp_ack; v.exp_data = exp_data; v.exp_held = exp_held; v.exp_err = exp_err;
    vecs.push_back(v);
  endfunction

  logic        g_ack;
  logic [63:0] g_data;
  logic [7:0]  g_dest;
  logic [7:0]  g_held;
  logic        g_err;

  initial begin
    bit ok;
    logic        e_ack;
    logic [63:0] e_data;
    logic [63:0] r64;
    logic [7:0]  code, id, tid;
    int          u, r;
    string       nm;

    for (int i = 0; i < 2; i++) begin
      rstn[i] = 1'b0; cmd_tvalid[i] = 1'b0; cmd_tdata[i] = '0;
      cmd_tid[i] = '0; ack_tready[i] = 1'b1;
    end

    // instance 0: silent unlocks
    add(0, 8'h04, 8'h2A, 8'd3, 48'h0,              1, 64'd1, 1, 0);
    add(0, 8'h04, 8'h2A, 8'd5, 48'hABCD_0000_1234, 1, 64'd0, 1, 0);
    add(0, 8'h06, 8'h2A, 8'd3, 48'h0,              0, 64'd0, 0, 0);
    add(0, 8'h04, 8'h2A, 8'd5, 48'h0,              1, 64'd1, 1, 0);
    add(0, 8'h06, 8'h2A, 8'd5, 48'h0,              0, 64'd0, 0, 0);
    add(0, 8'h04, 8'h01, 8'd1, 48'h0,              1, 64'd1, 1, 0);
    add(0, 8'h04, 8'h02, 8'd1, 48'h0,              1, 64'd1, 2, 0);
    add(0, 8'h04, 8'h03, 8'd1, 48'h0,              1, 64'd1, 3, 0);
    add(0, 8'h04, 8'h04, 8'd1, 48'h0,              1, 64'd1, 4, 0);
    add(0, 8'h04, 8'h05, 8'd2, 48'h0,              1, 64'd0, 4, 0);
    add(0, 8'h04, 8'h03, 8'd1, 48'h0,              1, 64'd0, 4, 0);
    add(0, 8'h06, 8'h02, 8'd1, 48'h0,              0, 64'd0, 3, 0);
    add(0, 8'h04, 8'h07, 8'd1, 48'hFFFF_FFFF_FFFF, 1, 64'd1, 4, 0);
    add(0, 8'h06, 8'h07, 8'd2, 48'h0,              0, 64'd0, 4, 1);
    add(0, 8'h06, 8'h01, 8'd1, 48'h0,              0, 64'd0, 3, 1);
    // instance 1: unlock ACKs
    add(1, 8'h04, 8'h07, 8'd1, 48'h0,              1, 64'd1, 1, 0);
    add(1, 8'h06, 8'h07, 8'd2, 48'h0,              1, 64'd0, 1, 1);
    add(1, 8'h06, 8'h07, 8'd1, 48'hFFFF_FFFF_FFFF, 1, 64'd1, 0, 1);
    add(1, 8'h06, 8'h33, 8'd1, 48'h0,              1, 64'd0, 0, 1);
    add(1, 8'h04, 8'h06, 8'd2, 48'h0,              1, 64'd1, 1, 1);
    add(1, 8'h00, 8'h06, 8'd2, 48'h0,              0, 64'd0, 1, 1);

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst%0d_tready", i), {63'd0, cmd_tready[i]}, 64'd0);
      check($sformatf("rst%0d_ack_valid", i), {63'd0, ack_tvalid[i]}, 64'd0);
      check($sformatf("rst%0d_ack_data", i), ack_tdata[i], 64'd0);
      check($sformatf("rst%0d_ack_dest", i), {56'd0, ack_tdest[i]}, 64'd0);
      check($sformatf("rst%0d_held", i), {{(64-CW){1'b0}}, locks_held[i]}, 64'd0);
      check($sformatf("rst%0d_err", i), {63'd0, err_sticky[i]}, 64'd0);
    end
    rstn[0] = 1'b1; rstn[1] = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      nm = $sformatf("v%0d", i);
      send(vecs[i].u, vecs[i].code, vecs[i].id, vecs[i].tid, vecs[i].hi, (i % 3), nm,
           g_ack, g_data, g_dest, g_held, g_err);
      check({nm, "_ack"}, {63'd0, g_ack}, {63'd0, vecs[i].exp_ack});
      if (vecs[i].exp_ack) begin
        check({nm, "_data"}, g_data, vecs[i].exp_data);
        check({nm, "_dest"}, {56'd0, g_dest}, {56'd0, vecs[i].tid});
      end
      check({nm, "_held"}, {56'd0, g_held}, 64'(vecs[i].exp_held));
      check({nm, "_err"}, {63'd0, g_err}, {63'd0, vecs[i].exp_err});
    end

    // ---- backpressure: instance 0 holds 3,4,7; lock 0x40 then 0x41 pending
    ack_tready[0] = 1'b0;
    wait_ready(0, "bp", ok);
    cmd_tvalid[0] = 1'b1;
    cmd_tdata[0]  = {48'd0, 8'h40, 8'h04};
    cmd_tid[0]    = 8'd6;
    @(posedge clk);
    #1;
    cmd_tdata[0]  = {48'd0, 8'h41, 8'h04};
    cmd_tid[0]    = 8'd7;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      check("bp_ack_valid", {63'd0, ack_tvalid[0]}, 64'd1);
      check("bp_ack_data", ack_tdata[0], 64'd1);
      check("bp_ack_dest", {56'd0, ack_tdest[0]}, 64'd6);
      check("bp_tready_low", {63'd0, cmd_tready[0]}, 64'd0);
      @(negedge clk);
    end
    ack_tready[0] = 1'b1;
    @(negedge clk);
    check("bp_release_ack_low", {63'd0, ack_tvalid[0]}, 64'd0);
    check("bp_release_tready", {63'd0, cmd_tready[0]}, 64'd1);
    @(posedge clk);
    #1;
    cmd_tvalid[0] = 1'b0;
    @(negedge clk);
    check("bp_second_accepted", {63'd0, cmd_tready[0]}, 64'd0);
    @(negedge clk);
    check("bp_second_ack_valid", {63'd0, ack_tvalid[0]}, 64'd1);
    check("bp_second_full_reject", ack_tdata[0], 64'd0);
    check("bp_second_dest", {56'd0, ack_tdest[0]}, 64'd7);
    check("bp_second_held", {{(64-CW){1'b0}}, locks_held[0]}, 64'd4);
    @(negedge clk);

    // ---- reset while in RESP
    ack_tready[0] = 1'b0;
    wait_ready(0, "rs", ok);
    cmd_tvalid[0] = 1'b1;
    cmd_tdata[0]  = {48'd0, 8'h03, 8'h04};
    cmd_tid[0]    = 8'd9;
    @(posedge clk);
    #1;
    cmd_tvalid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rs_ack_before", {63'd0, ack_tvalid[0]}, 64'd1);
    rstn[0] = 1'b0;
    #1;
    check("rs_ack_async_low", {63'd0, ack_tvalid[0]}, 64'd0);
    check("rs_tready_low", {63'd0, cmd_tready[0]}, 64'd0);
    check("rs_held", {{(64-CW){1'b0}}, locks_held[0]}, 64'd0);
    check("rs_err", {63'd0, err_sticky[0]}, 64'd0);
    check("rs_data", ack_tdata[0], 64'd0);
    @(negedge clk);
    @(negedge clk);
    rstn[0] = 1'b1;
    ack_tready[0] = 1'b1;
    send(0, 8'h09, 8'h03, 8'd9, 48'd0, 0, "rs_bad", g_ack, g_data, g_dest, g_held, g_err);
    check("rs_bad_noack", {63'd0, g_ack}, 64'd0);
    check("rs_bad_err", {63'd0, g_err}, 64'd1);
    check("rs_bad_held", {56'd0, g_held}, 64'd0);
    send(0, 8'h04, 8'h03, 8'd9, 48'd0, 0, "rs_relock", g_ack, g_data, g_dest, g_held, g_err);
    check("rs_relock_ack", {63'd0, g_ack}, 64'd1);
    check("rs_relock_data", g_data, 64'd1);
    check("rs_relock_dest", {56'd0, g_dest}, 64'd9);
    check("rs_relock_held", {56'd0, g_held}, 64'd1);

    // ---- random phase against the model
    rstn[0] = 1'b0; rstn[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn[0] = 1'b1; rstn[1] = 1'b1;
    model_clear();
    for (int n = 0; n < 240; n++) begin
      u  = int'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 99));
      id = 8'($urandom_range(0, 7));
      if (r < 50)      code = 8'h04;
      else if (r < 90) code = 8'h06;
      else begin
        case ($urandom_range(0, 3))
          0: code = 8'h00;
          1: code = 8'h05;
          2: code = 8'h09;
          default: code = 8'hFF;
        endcase
      end
      tid = 8'($urandom_range(0, 3));
      if (code == 8'h06 && m_held[u][id] && $urandom_range(0, 9) < 7) tid = m_own[u][id];
      r64 = {$urandom, $urandom};
      model_cmd(u, code, id, tid, e_ack, e_data);
      nm = $sformatf("rnd%0d_u%0d", n, u);
      send(u, code, id, tid, r64[47:0], int'($urandom_range(0, 3)), nm,
           g_ack, g_data, g_dest, g_held, g_err);
      check({nm, "_ack"}, {63'd0, g_ack}, {63'd0, e_ack});
      if (e_ack) begin
        check({nm, "_data"}, g_data, e_data);
        check({nm, "_dest"}, {56'd0, g_dest}, {56'd0, tid});
      end
      check({nm, "_held"}, {56'd0, g_held}, 64'(m_cnt[u]));
      check({nm, "_err"}, {63'd0, g_err}, {63'd0, m_err[u]});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
